// File: rtl/stage_fetch.sv
// Fetch-side PC, imem addressing, F/D latch and wrong-path squash.
// Define FETCH_PERF_EN to add saturating redirect/stall counters.
module stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] fd_insn,
    output logic [31:0] fd_pc_plus_4,
    output logic        fd_valid,
    output logic        flush_dx,
    output logic [4:0]  pc_upper_5
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_redirects,
    output logic [15:0] perf_stalls
`endif
);

    // BOOT drops the two responses straddling reset release.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        SQUASH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] issued_q;
    logic [31:0] issued_d;
    logic [31:0] insn_d;
    logic [31:0] pc4_d;
    logic        valid_d;
    logic        hold;
    logic        fetch_ok;

    assign hold       = stall_in & ~redirect_in;
    assign fetch_ok   = (state_q == RUN);
    assign imem_addr  = hold ? issued_q : pc_q;
    assign flush_dx   = redirect_in;
    assign pc_upper_5 = fd_pc_plus_4[31:27];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        issued_d = issued_q;
        insn_d   = fd_insn;
        pc4_d    = fd_pc_plus_4;
        valid_d  = fd_valid;
        if (redirect_in) begin
            state_d  = SQUASH;
            pc_d     = redirect_pc_in;
            issued_d = imem_addr;
            insn_d   = '0;
            valid_d  = 1'b0;
        end else if (!stall_in) begin
            pc_d     = pc_q + PC_INC;
            issued_d = imem_addr;
            insn_d   = fetch_ok ? imem_data : '0;
            pc4_d    = issued_q + PC_INC;
            valid_d  = fetch_ok;
            unique case (state_q)
                BOOT:    state_d = SQUASH;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            issued_q     <= RESET_PC;
            fd_insn      <= '0;
            fd_pc_plus_4 <= '0;
            fd_valid     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            issued_q     <= issued_d;
            fd_insn      <= insn_d;
            fd_pc_plus_4 <= pc4_d;
            fd_valid     <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_redirects <= '0;
            perf_stalls    <= '0;
        end else begin
            if (redirect_in && perf_redirects != 16'hFFFF)
                perf_redirects <= perf_redirects + 16'd1;
            if (hold && perf_stalls != 16'hFFFF)
                perf_stalls <= perf_stalls + 16'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch: directed fetch, stall,
// redirect, wrap and reset-mid-squash sequences.
module tb_stage_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] fd_insn;
    logic [31:0] fd_pc_plus_4;
    logic        fd_valid;
    logic        flush_dx;
    logic [4:0]  pc_upper_5;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_redirects;
    logic [15:0] perf_stalls;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];

    stage_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .fd_insn        (fd_insn),
        .fd_pc_plus_4   (fd_pc_plus_4),
        .fd_valid       (fd_valid),
        .flush_dx       (flush_dx),
`ifdef FETCH_PERF_EN
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls),
`endif
        .pc_upper_5     (pc_upper_5)
    );

    always #5 clock = ~clock;

    // Synchronous imem: word at address A reads as A + 0x100.
    always @(posedge clock)
        imem_data <= imem_addr + 32'h100;

    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b0 && fd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fd_stream: extra insn %h pc4 %h",
                         fd_insn, fd_pc_plus_4);
            end else begin
                e = exp_q.pop_front();
                if (fd_insn !== e.insn ||
                    fd_pc_plus_4 !== e.pc4 ||
                    pc_upper_5 !== e.pc4[31:27]) begin
                    errors++;
                    $display("FAIL fd_stream: got %h/%h/%h want %h/%h/%h",
                             fd_insn, fd_pc_plus_4, pc_upper_5,
                             e.insn, e.pc4, e.pc4[31:27]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic push(input logic [31:0] insn,
                        input logic [31:0] pc4);
        exp_t e;
        e.insn = insn;
        e.pc4  = pc4;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'd0, fd_valid}, 32'd0);
        chk({tag, "_insn"}, fd_insn, 32'd0);
        chk({tag, "_pc4"}, fd_pc_plus_4, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_upper"}, {27'd0, pc_upper_5}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush_dx}, 32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_r"}, {16'd0, perf_redirects}, 32'd0);
        chk({tag, "_perf_s"}, {16'd0, perf_stalls}, 32'd0);
`endif
    endtask

    initial begin
        reset          = 1'b1;
        stall_in       = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'd0;
        repeat (3) tick();
        chk_reset_state("rst");

        push(32'h101, 32'd2);
        push(32'h102, 32'd3);
        push(32'h103, 32'd4);
        repeat (4) push(32'h104, 32'd5);
        push(32'h105, 32'd6);
        push(32'h106, 32'd7);
        push(32'h107, 32'd8);
        push(32'h140, 32'h41);
        push(32'h141, 32'h42);
        push(32'h142, 32'h43);
        push(32'h180, 32'h81);
        push(32'h181, 32'h82);
        push(32'h0FE, 32'hFFFF_FFFF);
        push(32'h0FF, 32'h0);
        push(32'h100, 32'h1);
        push(32'h101, 32'h2);

        reset = 1'b0;
        #1 chk("c0_addr", imem_addr, 32'd0);
        tick();
        chk("c1_valid", {31'd0, fd_valid}, 32'd0);
        tick();
        chk("c2_valid", {31'd0, fd_valid}, 32'd0);
        chk("c2_addr", imem_addr, 32'd2);
        tick();
        chk("c3_valid", {31'd0, fd_valid}, 32'd1);
        chk("c3_pc4", fd_pc_plus_4, 32'd2);
        repeat (3) tick();

        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_addr", imem_addr, 32'd5);
            chk("stall_flush", {31'd0, flush_dx}, 32'd0);
            chk("stall_insn", fd_insn, 32'h104);
            tick();
        end
        stall_in = 1'b0;
        #1 chk("resume_addr", imem_addr, 32'd6);
        repeat (3) tick();

        redirect_in    = 1'b1;
        redirect_pc_in = 32'h40;
        #1 chk("redir_flush", {31'd0, flush_dx}, 32'd1);
        tick();
        redirect_in = 1'b0;
        #1;
        chk("n1_flush", {31'd0, flush_dx}, 32'd0);
        chk("n1_valid", {31'd0, fd_valid}, 32'd0);
        chk("n1_addr", imem_addr, 32'h40);
        tick();
        chk("n2_valid", {31'd0, fd_valid}, 32'd0);
        tick();
        chk("n3_valid", {31'd0, fd_valid}, 32'd1);
        repeat (2) tick();

        redirect_in    = 1'b1;
        stall_in       = 1'b1;
        redirect_pc_in = 32'h80;
        #1;
        chk("both_flush", {31'd0, flush_dx}, 32'd1);
        chk("both_addr", imem_addr, 32'h44);
        tick();
        redirect_in = 1'b0;
        stall_in    = 1'b0;
        #1;
        chk("both_pc", imem_addr, 32'h80);
        chk("both_valid", {31'd0, fd_valid}, 32'd0);
        repeat (3) tick();

        redirect_in    = 1'b1;
        redirect_pc_in = 32'hFFFF_FFFF;
        tick();
        redirect_pc_in = 32'hFFFF_FFFE;
        #1 chk("b2b_first", imem_addr, 32'hFFFF_FFFF);
        tick();
        redirect_in = 1'b0;
        #1 chk("b2b_last", imem_addr, 32'hFFFF_FFFE);
        tick();
        chk("wrap_m1", imem_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_0", imem_addr, 32'h0);
        chk("upper_1f", {27'd0, pc_upper_5}, 32'h1F);
        tick();
        chk("upper_00", {27'd0, pc_upper_5}, 32'h0);
        repeat (2) tick();

        redirect_in    = 1'b1;
        redirect_pc_in = 32'h300;
        tick();
        redirect_in = 1'b0;
        #1;
        chk("sq_addr", imem_addr, 32'h300);
`ifdef FETCH_PERF_EN
        chk("perf_redirects", {16'd0, perf_redirects}, 32'd5);
        chk("perf_stalls", {16'd0, perf_stalls}, 32'd3);
`endif
        reset = 1'b1;
        #1 chk_reset_state("midsq");
        repeat (2) tick();

        push(32'h101, 32'd2);
        push(32'h102, 32'd3);
        reset = 1'b0;
        repeat (3) tick();
        chk("rr_c3_valid", {31'd0, fd_valid}, 32'd1);
        tick();
        #6;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
